// File: rtl/pipelined_multiplier_nbits.sv
// pipelined_multiplier_nbits: 3-stage valid/ready multiplier, Baugh-Wooley signed/unsigned, carry-save reduction
module pipelined_multiplier_nbits #(
  parameter int WIDTH = 8,
  parameter int SIGNED_EN = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);
  localparam int PW = 2 * WIDTH;
  localparam logic [PW-1:0] BW_K = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));
  logic              w_adv;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic              r_sgn;
  logic              r_v1;
  logic              r_v2;
  logic              r_v3;
  logic [PW-1:0]     w_pp [WIDTH+1];
  logic [PW-1:0]     w_s;
  logic [PW-1:0]     w_c;
  logic [PW-1:0]     w_t;
  logic [PW-1:0]     r_sum;
  logic [PW-1:0]     r_carry;
  logic [PW-1:0]     r_product;
  assign w_adv     = !r_v3 || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_v3;
  assign product   = r_product;
  // S1: capture operands and mode; mode is forced unsigned when signed support is off
  always_ff @(posedge clk) begin
    if (rst) r_v1 <= 1'b0;
    else if (w_adv) begin
      r_v1  <= in_valid;
      r_a   <= A;
      r_b   <= B;
      r_sgn <= (SIGNED_EN != 0) && in_signed;
    end
  end
  // Partial products: in signed mode the sign-row/column cross terms are inverted and a constant row adds 2^W + 2^(2W-1)
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      w_pp[i] = '0;
      for (int j = 0; j < WIDTH; j++)
        w_pp[i][i+j] = (r_a[j] & r_b[i]) ^ (r_sgn && ((i == WIDTH - 1) != (j == WIDTH - 1)));
    end
    w_pp[WIDTH] = r_sgn ? BW_K : '0;
  end
  // Carry-save array: fold each partial-product row into a sum/carry pair with per-bit full adders
  always_comb begin
    w_s = w_pp[0];
    w_c = w_pp[1];
    w_t = '0;
    for (int i = 2; i <= WIDTH; i++) begin
      w_t = w_s ^ w_c ^ w_pp[i];
      w_c = ((w_s & w_c) | (w_s & w_pp[i]) | (w_c & w_pp[i])) << 1;
      w_s = w_t;
    end
  end
  // S2: hold the two carry-save rows
  always_ff @(posedge clk) begin
    if (rst) r_v2 <= 1'b0;
    else if (w_adv) begin
      r_v2    <= r_v1;
      r_sum   <= w_s;
      r_carry <= w_c;
    end
  end
  // S3: final carry-propagate add; held while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v3      <= 1'b0;
      r_product <= '0;
    end else if (w_adv) begin
      r_v3      <= r_v2;
      r_product <= r_sum + r_carry;
    end
  end
endmodule

// File: tb/tb_pipelined_multiplier_nbits.sv
// tb_pipelined_multiplier_nbits: directed checks of latency, modes, stalls, bubbles and reset
module tb_pipelined_multiplier_nbits;
  localparam int W = 8;
  localparam int N = 11;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic in_signed = 1'b0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [2*W-1:0] product;
  int total = 0;
  int bad = 0;
  int sent = 0;
  int got = 0;
  logic [W-1:0]   ta [N] = '{8'h00, 8'h01, 8'hFF, 8'h80, 8'hFF, 8'h7F, 8'h80, 8'h80, 8'h80, 8'h00, 8'h01};
  logic [W-1:0]   tb [N] = '{8'hFF, 8'hFF, 8'h80, 8'h80, 8'hFF, 8'h7F, 8'h01, 8'h7F, 8'hFF, 8'h80, 8'hFF};
  logic           ts [N] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [2*W-1:0] te [N] = '{16'h0000, 16'h00FF, 16'h7F80, 16'h4000, 16'h0001, 16'h3F01, 16'hFF80, 16'hC080, 16'h0080, 16'h0000, 16'hFFFF};
  always #5 clk = ~clk;
  pipelined_multiplier_nbits #(.WIDTH(W), .SIGNED_EN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
    .in_signed(in_signed), .out_valid(out_valid), .out_ready(out_ready), .product(product)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    in_valid = v;
    A = a;
    B = b;
    in_signed = s;
  endtask
  initial begin
    drive(1'b1, 8'h55, 8'h66, 1'b0);
    tick();
    tick();
    chk("rst_ov", out_valid, 0);
    chk("rst_prod", product, 0);
    chk("rst_ir", in_ready, 1);
    rst = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_discard", out_valid, 0);
    end
    drive(1'b1, 8'hFF, 8'hFF, 1'b0);
    tick();
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    chk("lat_c1", out_valid, 0);
    tick();
    chk("lat_c2", out_valid, 0);
    tick();
    chk("lat_c3_ov", out_valid, 1);
    chk("lat_c3_prod", product, 16'hFE01);
    tick();
    chk("lat_c4", out_valid, 0);
    drive(1'b1, 8'h80, 8'h80, 1'b1);
    tick();
    drive(1'b1, 8'hFF, 8'h02, 1'b1);
    tick();
    drive(1'b1, 8'hFF, 8'h02, 1'b0);
    tick();
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    chk("mix0_ov", out_valid, 1);
    chk("mix0", product, 16'h4000);
    tick();
    chk("mix1_ov", out_valid, 1);
    chk("mix1", product, 16'hFFFE);
    tick();
    chk("mix2_ov", out_valid, 1);
    chk("mix2", product, 16'h01FE);
    tick();
    chk("mix_end", out_valid, 0);
    drive(1'b1, 8'h03, 8'h05, 1'b0);
    tick();
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    tick();
    drive(1'b1, 8'h07, 8'h09, 1'b0);
    tick();
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    chk("bub0_ov", out_valid, 1);
    chk("bub0", product, 16'h000F);
    tick();
    chk("bub1_ov", out_valid, 0);
    tick();
    chk("bub2_ov", out_valid, 1);
    chk("bub2", product, 16'h003F);
    tick();
    chk("bub_end", out_valid, 0);
    drive(1'b1, 8'h80, 8'h7F, 1'b1);
    tick();
    drive(1'b1, 8'h12, 8'h34, 1'b0);
    tick();
    drive(1'b1, 8'hF0, 8'hF0, 1'b1);
    tick();
    out_ready = 1'b0;
    drive(1'b1, 8'h05, 8'h06, 1'b0);
    #1;
    chk("stall_ir0", in_ready, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_ov", out_valid, 1);
      chk("stall_prod", product, 16'hC080);
      chk("stall_ir", in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("rel_ir", in_ready, 1);
    tick();
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    chk("rel1", product, 16'h03A8);
    tick();
    chk("rel2", product, 16'h0100);
    tick();
    chk("rel3_ov", out_valid, 1);
    chk("rel3", product, 16'h001E);
    tick();
    chk("rel_end", out_valid, 0);
    drive(1'b1, 8'h02, 8'h03, 1'b0);
    tick();
    drive(1'b1, 8'h04, 8'h05, 1'b0);
    tick();
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_ov", out_valid, 0);
    chk("mrst_prod", product, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("mrst_drop", out_valid, 0);
    end
    for (int k = 0; k < 200 && got < N; k++) begin
      out_ready = (k % 3) != 2;
      if (sent < N) drive(1'b1, ta[sent], tb[sent], ts[sent]);
      else drive(1'b0, 8'h00, 8'h00, 1'b0);
      #1;
      if (out_valid && out_ready) begin
        chk("corner", product, te[got]);
        got++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    chk("corner_count", got, N);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipelined_multiplier_nbits.md
PIPELINED_MULTIPLIER_NBITS -- requirements
Module: pipelined_multiplier_nbits

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; legal range 4..32, even values only.
REQ-002 Parameter SIGNED_EN, default 1: 1 enables the per-transaction signed mode; 0 ties mode internally to unsigned.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand transfer request.
REQ-006 in_ready  output  1  block can accept operands this cycle.
REQ-007 A  input  WIDTH  multiplicand.
REQ-008 B  input  WIDTH  multiplier.
REQ-009 in_signed  input  1  1 = two's-complement operands; 0 = unsigned.
REQ-010 out_valid  output  1  product holds a valid result.
REQ-011 out_ready  input  1  downstream accepts the product this cycle.
REQ-012 product  output  2*WIDTH  full-precision product.

Function
REQ-013 Transfer in occurs when in_valid && in_ready; transfer out occurs when out_valid && out_ready.
REQ-014 Three register stages SHALL be used: S1 captures operands and mode; S2 holds partial products reduced by HA/FA compression to two carry-save rows; S3 holds the final carry-propagate sum.
REQ-015 Latency SHALL be exactly 3 cycles from input transfer to out_valid=1 when no stall occurs.
REQ-016 Throughput SHALL be 1 result per cycle while out_ready=1.
REQ-017 Each stage SHALL carry a valid bit. The signal advance = !out_valid || out_ready. All stages load only when advance=1, and in_ready = advance.
REQ-018 When advance=0, every stage register and its valid bit SHALL hold. product SHALL stay stable while out_valid=1 and out_ready=0.
REQ-019 Bubbles (stage valid=0) SHALL propagate without producing out_valid; a bubble stage's data contents are don't-care.
REQ-020 Unsigned mode: product = A*B, zero-extended operands, exact in 2*WIDTH bits.
REQ-021 Signed mode: product = the two's-complement product, exact in 2*WIDTH bits. This includes (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2).
REQ-022 Signed mode SHALL be implemented via sign-extension/Baugh-Wooley correction in the partial products, not by operand negation.
REQ-023 The mode SHALL travel with its data through the pipeline. Mixed-mode back-to-back transfers SHALL each produce the correct result.
REQ-024 When SIGNED_EN=0, in_signed SHALL be ignored.
REQ-025 in_valid=0 with in_ready=1 SHALL inject a bubble into S1.
REQ-026 A simultaneous output transfer and input transfer in the same cycle with a full pipeline SHALL lose no data.
REQ-027 No combinational path SHALL exist from in_valid, A, B, or in_signed to any output. in_ready depends combinationally only on out_ready and out_valid.

Reset
REQ-028 While rst=1 at a clock edge, all stage valid bits SHALL clear to 0, so out_valid=0 on the next cycle.
REQ-029 product SHALL reset to 0. Other data registers need not reset.
REQ-030 During rst=1, in_ready SHALL read 1 (out_valid=0) and input transfers SHALL be discarded.
REQ-031 Reset asserted mid-operation SHALL drop all in-flight results; no result from before reset SHALL appear after reset.

Verification
REQ-032 WIDTH=8, unsigned, A=0xFF, B=0xFF, out_ready=1 -> product=0xFE01 with out_valid=1 exactly 3 cycles after transfer.
REQ-033 WIDTH=8, signed, A=0x80, B=0x80 -> 0x4000. Signed A=0xFF, B=0x02 -> 0xFFFE. Unsigned A=0xFF, B=0x02 -> 0x01FE. These are sent back-to-back and SHALL appear on 3 consecutive cycles in order.
REQ-034 Stall: with the pipeline full of 3 results, hold out_ready=0 for 5 cycles -> in_ready=0, product constant, no loss. On release, results emerge in order, 1 per cycle.
REQ-035 Bubble pattern: in_valid toggles 1,0,1 -> out_valid pattern 1,0,1 starting at cycle 3.
REQ-036 Assert rst for 1 cycle with 2 results in flight -> out_valid=0 the following cycle and never reasserts for those operands.
REQ-037 Randomised check for WIDTH=8, 16, and 32: 10^5 random operands, modes, and out_ready patterns, compared against a reference model. SHALL show zero mismatches, including all corner operands 0, 1, max, and min-negative.
